// File: rtl/opb_msg_pkg.sv
// Shared definitions for the OPB message framer: default frame markers,
// FSM state encoding, the captured-access record and frame-length helper.
package opb_msg_pkg;

    // Default header and tail bytes, selected by access direction.
    localparam logic [7:0] HDR_WR_DEF  = 8'h5A;
    localparam logic [7:0] HDR_RD_DEF  = 8'h5B;
    localparam logic [7:0] TAIL_WR_DEF = 8'hA5;
    localparam logic [7:0] TAIL_RD_DEF = 8'hA4;

    // Widest address or data field the framer supports, in bytes.
    localparam int MAX_FIELD_BYTES = 4;

    // Framer states; HEAD..TAIL are the byte-emitting states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4,
        ST_TAIL = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    // One captured OPB access, sized for the widest configuration.
    typedef struct packed {
        logic                           rw;    // 1 = write, 0 = read
        logic [8*MAX_FIELD_BYTES-1:0]   addr;
        logic [8*MAX_FIELD_BYTES-1:0]   data;
    } capt_entry_t;

    // Bytes in one complete frame: header + address + data + checksum + tail.
    function automatic int frame_len(input int addr_bytes,
                                     input int data_bytes,
                                     input int chksum_en);
        return 2 + addr_bytes + data_bytes + chksum_en;
    endfunction

    // True for states that present a byte to the TX FIFO.
    function automatic logic is_emitting(input state_e s);
        return (s == ST_HEAD) || (s == ST_ADDR) || (s == ST_DATA) ||
               (s == ST_CHK)  || (s == ST_TAIL);
    endfunction

endpackage

// File: rtl/opb_msg_capt_fifo.sv
// Pending-access queue between the OPB strobes and the frame serialiser.
// First-word-fall-through: pop_data_o always shows the oldest entry.
// A push that meets a full queue is discarded and flagged on drop_o, even
// when a pop happens in the same cycle.
module opb_msg_capt_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             OPB_CLK,
    input  logic             OPB_RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Status flags and accepted-operation qualifiers.
    always_comb begin
        empty_o    = (wr_ptr_q == rd_ptr_q);
        full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push_ok    = push_i && !full_o;
        pop_ok     = pop_i && !empty_o;
        drop_o     = push_i && full_o;
        pop_data_o = mem_q[rd_ptr_q[PW-1:0]];
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // edge reading the pre-edge values, independent of statement order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written on accepted pushes.
    // NOTE: the array is deliberately not reset; emptying the queue only needs
    // the pointers, and stale contents are never read while empty.
    always_ff @(posedge OPB_CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/opb_msg_framer.sv
// OPB message framer: captures each OPB read/write strobe into a small
// queue and serialises it into header | address | data | [xor] | tail
// bytes towards the TX FIFO, with drop/timeout counters.
module opb_msg_framer
    import opb_msg_pkg::*;
#(
    parameter int         ADDR_BYTES    = 4,
    parameter int         DATA_BYTES    = 4,
    parameter int         CAPT_DEPTH    = 4,
    parameter int         TIMEOUT_TICKS = 200,
    parameter bit         CHKSUM_EN     = 1'b1,
    parameter logic [7:0] HDR_WR        = HDR_WR_DEF,
    parameter logic [7:0] HDR_RD        = HDR_RD_DEF,
    parameter logic [7:0] TAIL_WR       = TAIL_WR_DEF,
    parameter logic [7:0] TAIL_RD       = TAIL_RD_DEF
) (
    input  logic                    OPB_CLK,
    input  logic                    OPB_RST,
    input  logic                    TICK_EN,
    input  logic [8*ADDR_BYTES-1:0] OPB_ADDR,
    input  logic [8*DATA_BYTES-1:0] OPB_DO,
    input  logic [8*DATA_BYTES-1:0] OPB_DI,
    input  logic                    OPB_WE,
    input  logic                    OPB_RE,
    output logic [7:0]              TX_FIFO_DATA,
    output logic                    TX_FIFO_WR,
    input  logic                    TX_FIFO_FULL,
    output logic                    BUSY,
    output logic [15:0]             DROP_CNT,
    output logic [15:0]             ERR_CNT,
    output logic                    ERROR_FLAG
);

    localparam int AW      = 8 * ADDR_BYTES;
    localparam int DW      = 8 * DATA_BYTES;
    localparam int SW      = AW + DW;       // address+data shift register width
    localparam int EW      = 1 + SW;        // queue entry width
    localparam int STALL_W = $clog2(TIMEOUT_TICKS + 2);

    localparam bit                 TIMEOUT_ON = (TIMEOUT_TICKS > 0);
    localparam logic [STALL_W-1:0] STALL_LAST =
        (TIMEOUT_TICKS > 0) ? STALL_W'(TIMEOUT_TICKS - 1) : '0;
    localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
    logic          capt_push;
    logic [EW-1:0] capt_wdata;
    logic [EW-1:0] capt_rdata;
    logic          capt_pop;
    logic          capt_full;
    logic          capt_empty;
    logic          capt_drop;
    capt_entry_t   head;

    // A strobe on either line is one access; WE wins when both are set.
    always_comb begin
        capt_push  = OPB_WE || OPB_RE;
        capt_wdata = {OPB_WE, OPB_ADDR, (OPB_WE ? OPB_DO : OPB_DI)};
    end

    opb_msg_capt_fifo #(
        .WIDTH (EW),
        .DEPTH (CAPT_DEPTH)
    ) u_capt_fifo (
        .OPB_CLK     (OPB_CLK),
        .OPB_RST     (OPB_RST),
        .push_i      (capt_push),
        .push_data_i (capt_wdata),
        .pop_i       (capt_pop),
        .pop_data_o  (capt_rdata),
        .full_o      (capt_full),
        .empty_o     (capt_empty),
        .drop_o      (capt_drop)
    );

    // Unpack the oldest queued access into named fields.
    always_comb begin
        head          = '0;
        head.rw       = capt_rdata[EW-1];
        head.addr[AW-1:0] = capt_rdata[EW-2 -: AW];
        head.data[DW-1:0] = capt_rdata[DW-1:0];
    end

    // ------------------------------------------------------------------
    // Frame serialiser
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;       // byte index within ADDR / DATA
    logic [SW-1:0]      sh_q, sh_d;         // address then data, MSB byte first
    logic [7:0]         chk_q, chk_d;       // running XOR of emitted bytes
    logic               rw_q, rw_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic       emitting;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       timeout_hit;
    logic       start_frame;
    logic       err_inc;

    // State register and datapath registers.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            chk_q      <= '0;
            rw_q       <= 1'b0;
            stall_q    <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            chk_q      <= chk_d;
            rw_q       <= rw_d;
            stall_q    <= stall_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic: field sequencing, byte acceptance, stall timeout.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        chk_d       = chk_q;
        rw_d        = rw_q;
        stall_d     = stall_q;
        start_frame = 1'b0;
        capt_pop    = 1'b0;
        err_inc     = 1'b0;

        timeout_hit = TIMEOUT_ON && emitting && TX_FIFO_FULL && TICK_EN &&
                      (stall_q == STALL_LAST);

        if (tx_wr) begin
            stall_d = '0;
        end else if (emitting && TX_FIFO_FULL && TICK_EN) begin
            stall_d = stall_q + STALL_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                start_frame = !capt_empty;
            end
            ST_HEAD: begin
                if (tx_wr) begin
                    chk_d   = chk_q ^ tx_data;
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (tx_wr) begin
                    chk_d = chk_q ^ tx_data;
                    sh_d  = {sh_q[SW-9:0], 8'h00};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tx_wr) begin
                    chk_d = chk_q ^ tx_data;
                    sh_d  = {sh_q[SW-9:0], 8'h00};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = CHKSUM_EN ? ST_CHK : ST_TAIL;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_CHK: begin
                if (tx_wr) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (tx_wr) begin
                    if (!capt_empty) begin
                        start_frame = 1'b1;   // zero-gap follow-on frame
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load the oldest access and begin a new frame at its header.
        if (start_frame) begin
            capt_pop = 1'b1;
            rw_d     = head.rw;
            sh_d     = {head.addr[AW-1:0], head.data[DW-1:0]};
            chk_d    = '0;
            cnt_d    = '0;
            stall_d  = '0;
            state_d  = ST_HEAD;
        end

        // A stall timeout abandons the rest of the frame; the queue is kept.
        if (timeout_hit) begin
            state_d = ST_ERR;
            err_inc = 1'b1;
        end
    end

    // Saturating drop / error counters.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (capt_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Output decode from registered state: byte mux and write strobe.
    always_comb begin
        emitting = is_emitting(state_q);
        tx_wr    = emitting && !TX_FIFO_FULL;
        tx_data  = 8'h00;
        unique case (state_q)
            ST_HEAD:          tx_data = rw_q ? HDR_WR : HDR_RD;
            ST_ADDR, ST_DATA: tx_data = sh_q[SW-1 -: 8];
            ST_CHK:           tx_data = chk_q;
            ST_TAIL:          tx_data = rw_q ? TAIL_WR : TAIL_RD;
            default:          tx_data = 8'h00;
        endcase
    end

    assign TX_FIFO_WR   = tx_wr;
    assign TX_FIFO_DATA = tx_data;
    assign BUSY         = (state_q != ST_IDLE) || !capt_empty;
    assign DROP_CNT     = drop_cnt_q;
    assign ERR_CNT      = err_cnt_q;
    assign ERROR_FLAG   = (state_q == ST_ERR);

endmodule

// File: tb/tb_opb_msg_framer.sv
// Self-checking bench for opb_msg_framer: a reference model builds each
// expected frame from the access itself and queues its bytes; a monitor
// pops and compares every byte the DUT writes to the TX FIFO.
module tb_opb_msg_framer;
    import opb_msg_pkg::*;

    localparam int AB  = 4;
    localparam int DB  = 4;
    localparam int CK  = 1;
    localparam int TO  = 3;
    localparam int FL  = frame_len(AB, DB, CK);

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_BOTH = 2;

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST;
    logic        TICK_EN;
    logic [31:0] OPB_ADDR;
    logic [31:0] OPB_DO;
    logic [31:0] OPB_DI;
    logic        OPB_WE;
    logic        OPB_RE;
    logic [7:0]  TX_FIFO_DATA;
    logic        TX_FIFO_WR;
    logic        TX_FIFO_FULL;
    logic        BUSY;
    logic [15:0] DROP_CNT;
    logic [15:0] ERR_CNT;
    logic        ERROR_FLAG;

    opb_msg_framer #(
        .ADDR_BYTES    (AB),
        .DATA_BYTES    (DB),
        .CAPT_DEPTH    (4),
        .TIMEOUT_TICKS (TO),
        .CHKSUM_EN     (1'b1)
    ) dut (
        .OPB_CLK      (OPB_CLK),
        .OPB_RST      (OPB_RST),
        .TICK_EN      (TICK_EN),
        .OPB_ADDR     (OPB_ADDR),
        .OPB_DO       (OPB_DO),
        .OPB_DI       (OPB_DI),
        .OPB_WE       (OPB_WE),
        .OPB_RE       (OPB_RE),
        .TX_FIFO_DATA (TX_FIFO_DATA),
        .TX_FIFO_WR   (TX_FIFO_WR),
        .TX_FIFO_FULL (TX_FIFO_FULL),
        .BUSY         (BUSY),
        .DROP_CNT     (DROP_CNT),
        .ERR_CNT      (ERR_CNT),
        .ERROR_FLAG   (ERROR_FLAG)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    int cyc = 0;
    always @(posedge OPB_CLK) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         acc_cyc[$];
    int         acc_total = 0;
    int         err_seen  = 0;
    int         checks    = 0;
    int         errors    = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame bytes straight from the framing rules.
    task automatic push_frame(input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input int nbytes);
        logic [7:0] f[$];
        logic [7:0] x;
        f.push_back(wr ? 8'h5A : 8'h5B);
        for (int i = AB - 1; i >= 0; i--) f.push_back(a[8*i +: 8]);
        for (int i = DB - 1; i >= 0; i--) f.push_back(d[8*i +: 8]);
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        if (CK != 0) f.push_back(x);
        f.push_back(wr ? 8'hA5 : 8'hA4);
        for (int i = 0; i < nbytes && i < f.size(); i++) exp_q.push_back(f[i]);
    endtask

    // Monitor / scoreboard: every accepted byte must match the model.
    always @(negedge OPB_CLK) begin
        if (!OPB_RST) begin
            if (TX_FIFO_WR) begin
                check("wr_while_full", {31'd0, TX_FIFO_FULL}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)",
                             TX_FIFO_DATA, cyc);
                end else begin
                    check("frame_byte", {24'd0, TX_FIFO_DATA}, {24'd0, exp_q.pop_front()});
                end
                acc_cyc.push_back(cyc);
                acc_total++;
            end
            if (ERROR_FLAG) err_seen++;
        end
    end

    task automatic step();
        @(posedge OPB_CLK);
        #1;
    endtask

    // One strobe cycle; nbytes of its frame are expected on the TX side.
    task automatic access(input int kind, input logic [31:0] a,
                          input logic [31:0] d, input int nbytes, output int n);
        step();
        n        = cyc;
        OPB_ADDR = a;
        OPB_WE   = (kind != K_RD);
        OPB_RE   = (kind != K_WR);
        OPB_DO   = (kind != K_RD) ? d : $urandom();
        OPB_DI   = (kind == K_RD) ? d : $urandom();
        push_frame(kind != K_RD, a, d, nbytes);
    endtask

    task automatic idle();
        step();
        OPB_WE = 1'b0;
        OPB_RE = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < budget) begin
            @(negedge OPB_CLK);
            n++;
        end
        #1;
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int k;
        int kind;

        OPB_RST = 1'b1; TICK_EN = 1'b0; OPB_WE = 1'b0; OPB_RE = 1'b0;
        OPB_ADDR = '0; OPB_DO = '0; OPB_DI = '0; TX_FIFO_FULL = 1'b0;
        repeat (3) @(posedge OPB_CLK);
        #1;
        check("rst_wr",    {31'd0, TX_FIFO_WR}, 0);
        check("rst_data",  {24'd0, TX_FIFO_DATA}, 0);
        check("rst_busy",  {31'd0, BUSY}, 0);
        check("rst_drop",  {16'd0, DROP_CNT}, 0);
        check("rst_err",   {16'd0, ERR_CNT}, 0);
        check("rst_eflag", {31'd0, ERROR_FLAG}, 0);
        @(negedge OPB_CLK);
        OPB_RST = 1'b0;

        // Directed write: header two cycles after the strobe, 11 contiguous bytes.
        acc_cyc.delete();
        access(K_WR, 32'h0000_1234, 32'hDEAD_BEEF, FL, n);
        idle();
        wait_drain("wr_frame", 100);
        check("wr_len", acc_cyc.size(), FL);
        if (acc_cyc.size() == FL) begin
            check("wr_latency", acc_cyc[0] - n, 2);
            check("wr_contig", acc_cyc[FL-1] - acc_cyc[0], FL - 1);
        end

        // Directed read.
        access(K_RD, 32'h0000_0010, 32'h0000_0001, FL, n);
        idle();
        wait_drain("rd_frame", 100);

        // Random bursts of 1..4 back-to-back accesses (never overflows the queue).
        for (int b = 0; b < 6; b++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                kind = $urandom_range(0, 2);
                access(kind, $urandom(), $urandom(), FL, n);
            end
            idle();
            wait_drain("rand_burst", 300);
        end

        // Queue overflow: FULL held, six writes, the sixth is lost.
        acc_cyc.delete();
        TX_FIFO_FULL = 1'b1;
        for (int j = 0; j < 6; j++) begin
            access(K_WR, $urandom(), $urandom(), (j < 5) ? FL : 0, n);
        end
        idle();
        step();
        check("drop_cnt", {16'd0, DROP_CNT}, 1);
        check("no_bytes_while_full", acc_cyc.size(), 0);
        TX_FIFO_FULL = 1'b0;
        wait_drain("overflow", 400);
        check("overflow_len", acc_cyc.size(), 5 * FL);
        if (acc_cyc.size() == 5 * FL) begin
            check("overflow_contig", acc_cyc[5*FL-1] - acc_cyc[0], 5 * FL - 1);
        end

        // Random FULL toggling during one frame.
        access(K_WR, $urandom(), $urandom(), FL, n);
        idle();
        for (int j = 0; j < 400 && exp_q.size() != 0; j++) begin
            step();
            TX_FIFO_FULL = 1'($urandom_range(0, 1));
        end
        step();
        TX_FIFO_FULL = 1'b0;
        wait_drain("full_toggle", 100);

        // Stall timeout after the header; a queued write survives.
        access(K_WR, $urandom(), $urandom(), 1, n);    // N
        idle();                                        // N+1
        step();                                        // N+2: header out
        step();                                        // N+3
        TX_FIFO_FULL = 1'b1;
        access(K_WR, $urandom(), $urandom(), FL, n);
        idle();
        for (int j = 0; j < TO; j++) begin
            step(); TICK_EN = 1'b1;
            step(); TICK_EN = 1'b0;
            step();
        end
        for (int j = 0; j < 10 && err_seen == 0; j++) @(negedge OPB_CLK);
        repeat (4) @(negedge OPB_CLK);
        #1;
        check("eflag_pulse", err_seen, 1);
        check("err_cnt", {16'd0, ERR_CNT}, 1);
        check("busy_queued", {31'd0, BUSY}, 1);
        step();
        TX_FIFO_FULL = 1'b0;
        wait_drain("after_timeout", 100);

        // Reset after the fourth byte of a frame.
        base = acc_total;
        access(K_WR, $urandom(), $urandom(), 4, n);
        idle();
        for (int j = 0; j < 30 && (acc_total - base) < 4; j++) begin
            @(negedge OPB_CLK);
            #1;
        end
        check("bytes_before_rst", acc_total - base, 4);
        OPB_RST = 1'b1;
        #1;
        check("rst2_wr",    {31'd0, TX_FIFO_WR}, 0);
        check("rst2_data",  {24'd0, TX_FIFO_DATA}, 0);
        check("rst2_busy",  {31'd0, BUSY}, 0);
        check("rst2_drop",  {16'd0, DROP_CNT}, 0);
        check("rst2_err",   {16'd0, ERR_CNT}, 0);
        check("rst2_eflag", {31'd0, ERROR_FLAG}, 0);
        repeat (2) @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        access(K_BOTH, $urandom(), $urandom(), FL, n);
        idle();
        wait_drain("after_rst", 100);

        check("eflag_total", err_seen, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
